// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 memory responder: word/byte geometry,
// loader state encoding and the byte-lane placement helper.
package rv32_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] place_byte(
        input logic [BYTE_W-1:0] b,
        input logic [LANE_W-1:0] lane
    );
        place_byte = {{(WORD_W-BYTE_W){1'b0}}, b} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/rv32_ram_1rw.sv
// Single-port synchronous word RAM, read-before-write, with a resettable
// read register that can also be cleared synchronously.
module rv32_ram_1rw
    import rv32_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  re,
    input  logic                  we,
    input  logic                  rclr,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];
    logic [WORD_W-1:0] rdata_r;

    // Storage array: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register; sampling the old contents gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (rclr) begin
            rdata_r <= {WORD_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rv32_mem_responder.sv
// Memory-side responder for the rv32 core: boot-loads a word RAM from a
// byte stream while holding the core in reset, then serves core reads/writes.
module rv32_mem_responder
    import rv32_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int BOOT_LOAD  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_W-1:0]     mem_wdata,
    output logic [WORD_W-1:0]     mem_rdata,
    input  logic                  ld_valid,
    input  logic [BYTE_W-1:0]     ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  core_reset,
    output logic [DEPTH_LOG2:0]   ld_words,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_CNT     = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam state_t              RESET_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;

    state_t                state_r;
    logic [LANE_W-1:0]     lane_r;
    logic [WORD_W-1:0]     asm_r;
    logic [DEPTH_LOG2:0]   ld_words_r;
    logic                  err_r;
    logic                  core_reset_r;
    logic                  ld_ready_r;

    logic                  accept_s;
    logic                  word_done_s;
    logic                  room_s;
    logic                  in_range_s;
    logic [WORD_W-1:0]     word_s;
    logic                  ram_re_s;
    logic                  ram_we_s;
    logic                  ram_rclr_s;
    logic [DEPTH_LOG2-1:0] ram_addr_s;
    logic [WORD_W-1:0]     ram_wdata_s;

    // Byte assembly, range checks and RAM port steering between loader and core.
    always_comb begin
        accept_s    = (state_r == ST_LOAD) && ld_valid && ld_ready_r;
        word_s      = asm_r | place_byte(ld_byte, lane_r);
        word_done_s = accept_s && ((lane_r == 2'd3) || ld_last);
        room_s      = (ld_words_r != FULL_CNT);
        in_range_s  = ((mem_addr >> DEPTH_LOG2) == {ADDR_WIDTH{1'b0}});
        ram_re_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_rclr_s  = 1'b0;
        ram_addr_s  = ld_words_r[DEPTH_LOG2-1:0];
        ram_wdata_s = word_s;
        if (state_r == ST_RUN) begin
            ram_addr_s  = mem_addr[DEPTH_LOG2-1:0];
            ram_wdata_s = mem_wdata;
            ram_re_s    = mem_rd && in_range_s;
            ram_we_s    = mem_wr && in_range_s;
            ram_rclr_s  = mem_rd && !in_range_s;
        end else begin
            ram_we_s    = word_done_s && room_s;
        end
    end

    // Loader FSM with registered handshake, core reset and error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= RESET_STATE;
            lane_r       <= 2'd0;
            asm_r        <= {WORD_W{1'b0}};
            ld_words_r   <= {(DEPTH_LOG2+1){1'b0}};
            err_r        <= 1'b0;
            core_reset_r <= 1'b1;
            ld_ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    core_reset_r <= 1'b1;
                    if (accept_s) begin
                        if (word_done_s) begin
                            lane_r <= 2'd0;
                            asm_r  <= {WORD_W{1'b0}};
                            if (room_s) begin
                                ld_words_r <= ld_words_r + ONE_CNT;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else begin
                            lane_r <= lane_r + 2'd1;
                            asm_r  <= word_s;
                        end
                        if (ld_last) begin
                            state_r    <= ST_FLUSH;
                            ld_ready_r <= 1'b0;
                        end else begin
                            ld_ready_r <= 1'b1;
                        end
                    end else begin
                        ld_ready_r <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ld_ready_r <= 1'b0;
                    state_r    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    core_reset_r <= 1'b0;
                    state_r      <= ST_RUN;
                end
                ST_RUN: begin
                    core_reset_r <= 1'b0;
                    ld_ready_r   <= 1'b0;
                    if ((mem_rd || mem_wr) && !in_range_s) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= RESET_STATE;
                    core_reset_r <= 1'b1;
                    ld_ready_r   <= 1'b0;
                end
            endcase
        end
    end

    rv32_ram_1rw #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset_n),
        .re    (ram_re_s),
        .we    (ram_we_s),
        .rclr  (ram_rclr_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (mem_rdata)
    );

    assign ld_ready   = ld_ready_r;
    assign core_reset = core_reset_r;
    assign ld_words   = ld_words_r;
    assign err        = err_r;

endmodule

// File: doc/rv32_mem_responder.md
Name: rv32_mem_responder

Overview:
- Memory-side responder for the rv32 core's bus. It answers the core's mem_rd/mem_wr requests from a word-addressed on-chip RAM.
- The core's address is a word index, because PC steps by 1.
- Before the core runs, the RAM is filled through a byte-stream boot-load port. During load the block holds the core in reset and releases it once loading completes.
- Sits between the rv32 core and the board-level loader (for example a UART byte receiver).

Parameters:
- ADDR_WIDTH, 32, width of the core address bus (mem_addr).
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words).
- BOOT_LOAD, 1, 1 = enter LOAD after reset; 0 = go directly to RUN with core_reset low.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_rd  in  1  core read request, one-cycle pulse.
- mem_wr  in  1  core write request, one-cycle pulse.
- mem_addr  in  ADDR_WIDTH  core word address.
- mem_wdata  in  32  core store data.
- mem_rdata  out  32  read data returned to the core.
- ld_valid  in  1  a boot byte is present this cycle.
- ld_byte  in  8  boot byte; bytes arrive LSB-first within each word.
- ld_last  in  1  qualifies the final byte of the image (valid only with ld_valid).
- ld_ready  out  1  responder accepts boot bytes.
- core_reset  out  1  active-high reset driven into the rv32 core.
- ld_words  out  DEPTH_LOG2+1  number of words written by the loader.
- err  out  1  sticky error: out-of-range access or load overflow.

Behaviour:
- Reset (async, reset_n=0) sets every output:
  - mem_rdata=0, ld_words=0, err=0.
  - core_reset=1, ld_ready=0.
  - state=LOAD if BOOT_LOAD else RUN.
  - byte lane=0, word pointer=0.
  - RAM contents are not reset.
- On reset release in RUN (BOOT_LOAD=0), core_reset deasserts at the first clock edge.
- States: LOAD, FLUSH, RELEASE, RUN.
- LOAD:
  - ld_ready=1, core_reset=1. Core-side requests are ignored and mem_rdata is held.
  - A byte is accepted when ld_valid=1 at a clock edge. It is placed in lane k (bits 8k+7:8k) of the assembly register, and k increments.
  - When lane 3 fills, the word is written to RAM[ptr], ptr increments, ld_words increments and k returns to 0. All of this happens on the same edge.
  - ld_valid & ld_last: the byte is placed normally. Unfilled upper lanes are zero-padded, the word is written that cycle (even if k<3), and the state goes to FLUSH.
  - If ptr reaches 2^DEPTH_LOG2, further words are dropped, err sets, and ld_words saturates at 2^DEPTH_LOG2. Loading still ends on ld_last.
- FLUSH: one cycle; ld_ready=0. Guarantees the final RAM write has landed before the core fetches.
- RELEASE: one cycle; core_reset deasserts at the end of this cycle, then the state goes to RUN.
- RUN:
  - ld_ready=0, ld_valid is ignored, core_reset=0.
  - Read (mem_rd=1 at edge N): mem_rdata <= RAM[mem_addr[DEPTH_LOG2-1:0]] at edge N. The value is valid the cycle after the request and is held until the next read. This matches the core's one-cycle delay state before it samples.
  - Write (mem_wr=1 at edge N): RAM[index] <= mem_wdata at edge N. mem_rdata is unchanged.
  - mem_rd & mem_wr together: the write is performed and mem_rdata returns the previous contents (read-before-write).
  - mem_addr >= 2^DEPTH_LOG2 (any upper bit set): reads return 0, writes are dropped, err sets.
- err is cleared only by reset_n.
- Reset asserted mid-load or mid-run returns to the reset state immediately. The core is re-held in reset, and any partial assembly word is discarded.

Decomposition:
- Shared package (rv32_pkg) holds:
  - the state encoding constants (LOAD/FLUSH/RELEASE/RUN);
  - WORD_W=32 and BYTE_W=8;
  - the lane count of 4.
- One sub-module, rv32_ram_1rw: a single-port synchronous RAM with read-before-write semantics, parameterised by DEPTH_LOG2.
- The loader FSM, byte assembler and range checks stay in the top module.

Test Plan:
- Load bytes 13,05,00,00,93,00,10,00 (last on the 8th byte):
  - expect RAM[0]=0x00000513 and RAM[1]=0x00100093;
  - ld_words=2;
  - core_reset falls 2 cycles after the last byte (FLUSH, RELEASE).
- Load 5 bytes AA,BB,CC,DD,EE with ld_last on EE -> RAM[1]=0x000000EE (zero-padded), ld_words=2.
- RUN: pulse mem_rd with addr 1 -> mem_rdata=0x00100093 the next cycle, held until the next read.
- RUN: mem_wr addr 3 data 0xDEADBEEF, then mem_rd addr 3 -> 0xDEADBEEF. Then simultaneous rd+wr addr 3 with data 0x12345678 -> mem_rdata=0xDEADBEEF, and a later read returns 0x12345678.
- RUN: mem_rd addr 0x400 (DEPTH_LOG2=10) -> mem_rdata=0 and err=1. A subsequent mem_wr to addr 0x400 changes nothing in RAM.
- Assert reset_n low after 2 bytes of load -> core_reset=1 and ld_words=0. A fresh 4-byte load starts at RAM[0] with lane 0.
